// File: rtl/m_store_buffer_pkg.sv
// m_store_buffer_pkg: store-op codes, default address map, FIFO entry type and range helper.
package m_store_buffer_pkg;
  localparam logic [2:0] BE_SW = 3'd1;
  localparam logic [2:0] BE_SH = 3'd2;
  localparam logic [2:0] BE_SB = 3'd3;
  localparam logic [31:0] DM_BEGIN_D  = 32'h0000_0000;
  localparam logic [31:0] DM_END_D    = 32'h0000_2FFF;
  localparam logic [31:0] TC1_BEGIN_D = 32'h0000_7F00;
  localparam logic [31:0] TC1_END_D   = 32'h0000_7F0B;
  localparam logic [31:0] TC2_BEGIN_D = 32'h0000_7F10;
  localparam logic [31:0] TC2_END_D   = 32'h0000_7F1B;
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } sb_entry_t;
  // Unsigned wrap-around trick: one subtract-compare per range, no lower-bound compare against zero.
  function automatic logic in_rng(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a - lo) <= (hi - lo);
  endfunction
endpackage

// File: rtl/m_store_buffer_fmt.sv
// m_store_fmt: byte-enable/data formatting for sw/sh/sb and store address exception detection.
module m_store_fmt
  import m_store_buffer_pkg::*;
#(
  parameter logic [31:0] DM_BEGIN  = DM_BEGIN_D,
  parameter logic [31:0] DM_END    = DM_END_D,
  parameter logic [31:0] TC1_BEGIN = TC1_BEGIN_D,
  parameter logic [31:0] TC1_END   = TC1_END_D,
  parameter logic [31:0] TC2_BEGIN = TC2_BEGIN_D,
  parameter logic [31:0] TC2_END   = TC2_END_D
) (
  input  logic        i_store,
  input  logic [2:0]  i_beop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rt,
  input  logic        i_dmov,
  output logic        o_valid_op,
  output logic [3:0]  o_byteen,
  output logic [31:0] o_wdata,
  output logic        o_ades
);
  logic w_sw, w_sh, w_sb, w_mis, w_oor, w_terr;
  always_comb begin
    w_sw = i_beop == BE_SW;
    w_sh = i_beop == BE_SH;
    w_sb = i_beop == BE_SB;
    o_valid_op = w_sw | w_sh | w_sb;
    o_byteen = w_sw ? 4'hF :
               w_sh ? (i_addr[1] ? 4'hC : 4'h3) :
               w_sb ? 4'b0001 << i_addr[1:0] : 4'h0;
    o_wdata = w_sw ? i_rt :
              w_sh ? (i_addr[1] ? {i_rt[15:0], 16'h0} : {16'h0, i_rt[15:0]}) :
              w_sb ? {24'h0, i_rt[7:0]} << {i_addr[1:0], 3'b000} : 32'h0;
    w_mis = (w_sw & |i_addr[1:0]) | (w_sh & i_addr[0]);
    w_oor = ~(in_rng(i_addr, DM_BEGIN, DM_END) | in_rng(i_addr, TC1_BEGIN, TC1_END) |
              in_rng(i_addr, TC2_BEGIN, TC2_END));
    // Timer count registers are read-only and timers only take full-word writes.
    w_terr = in_rng(i_addr, TC1_BEGIN + 32'd8, TC1_BEGIN + 32'd11) |
             in_rng(i_addr, TC2_BEGIN + 32'd8, TC2_BEGIN + 32'd11) |
             (~w_sw & (i_addr >= TC1_BEGIN));
    o_ades = i_store & (w_mis | w_oor | w_terr | i_dmov);
  end
endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: queues formatted M-stage stores in a DEPTH-entry FIFO, drains them in order over valid/ready.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] DM_BEGIN  = DM_BEGIN_D,
  parameter logic [31:0] DM_END    = DM_END_D,
  parameter logic [31:0] TC1_BEGIN = TC1_BEGIN_D,
  parameter logic [31:0] TC1_END   = TC1_END_D,
  parameter logic [31:0] TC2_BEGIN = TC2_BEGIN_D,
  parameter logic [31:0] TC2_END   = TC2_END_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store,
  input  logic [2:0]  BEOp,
  input  logic [31:0] Addr,
  input  logic [31:0] rt_data,
  input  logic        EXC_DMOv,
  input  logic        Req,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        EXC_AdES,
  output logic        stall_full,
  output logic        ld_hit,
  output logic        empty,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  sb_entry_t        r_q [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_valid_op, w_enq, w_deq, w_hit;
  logic [3:0]       w_byteen;
  logic [31:0]      w_wdata;
  logic [PW-1:0]    w_rd_nx, w_wr_nx;
  logic [DEPTH-1:0] w_set, w_clr;
  sb_entry_t        w_head;
  logic             w_unused;
  m_store_fmt #(
    .DM_BEGIN(DM_BEGIN), .DM_END(DM_END),
    .TC1_BEGIN(TC1_BEGIN), .TC1_END(TC1_END),
    .TC2_BEGIN(TC2_BEGIN), .TC2_END(TC2_END)
  ) u_fmt (
    .i_store(store), .i_beop(BEOp), .i_addr(Addr), .i_rt(rt_data), .i_dmov(EXC_DMOv),
    .o_valid_op(w_valid_op), .o_byteen(w_byteen), .o_wdata(w_wdata), .o_ades(EXC_AdES)
  );
  assign w_unused = ^ld_addr[1:0];
  always_comb begin
    empty      = r_cnt == '0;
    bus_valid  = ~empty;
    stall_full = store & (r_cnt == CW'(DEPTH));
    w_enq      = store & ~Req & ~EXC_AdES & ~stall_full & w_valid_op;
    w_deq      = bus_valid & bus_ready;
    w_rd_nx    = (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
    w_wr_nx    = (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
    w_set      = DEPTH'(w_enq) << r_wr;
    w_clr      = DEPTH'(w_deq) << r_rd;
    w_head     = r_q[r_rd];
    bus_addr   = bus_valid ? {w_head.waddr, 2'b00} : 32'h0;
    bus_byteen = bus_valid ? w_head.byteen : 4'h0;
    bus_wdata  = bus_valid ? w_head.wdata : 32'h0;
  end
  // Only occupied slots compare; an entry being written this cycle is not yet occupied.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && r_q[i].waddr == ld_addr[31:2]) w_hit = 1'b1;
    ld_hit = ld_valid & w_hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      if (w_enq) begin
        r_q[r_wr] <= '{waddr: Addr[31:2], byteen: w_byteen, wdata: w_wdata};
        r_wr      <= w_wr_nx;
      end
      if (w_deq) r_rd <= w_rd_nx;
      r_vld <= (r_vld & ~w_clr) | w_set;
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: directed scenarios plus randomized traffic checked against a queue-based store model.
module tb_m_store_buffer;
  import m_store_buffer_pkg::*;
  logic clk = 1'b0;
  logic reset, store, EXC_DMOv, Req, ld_valid, bus_ready;
  logic [2:0] BEOp;
  logic [31:0] Addr, rt_data, ld_addr;
  logic EXC_AdES, stall_full, ld_hit, empty, bus_valid;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0] bus_byteen;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [29:0] wa;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];

  m_store_buffer dut (
    .clk(clk), .reset(reset), .store(store), .BEOp(BEOp), .Addr(Addr), .rt_data(rt_data),
    .EXC_DMOv(EXC_DMOv), .Req(Req), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .EXC_AdES(EXC_AdES), .stall_full(stall_full), .ld_hit(ld_hit), .empty(empty),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] b;
    b = 4'h0;
    if (op == BE_SW) b = 4'hF;
    else if (op == BE_SH) b = a[1] ? 4'hC : 4'h3;
    else if (op == BE_SB) b[a[1:0]] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_data(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rt);
    logic [31:0] d;
    logic [3:0] be;
    d = 32'h0;
    be = m_be(op, a);
    for (int i = 0; i < 4; i++)
      if (be[i]) d[8*i +: 8] = (op == BE_SB) ? rt[7:0] : (op == BE_SH) ? rt[8*(i%2) +: 8] : rt[8*i +: 8];
    return d;
  endfunction

  function automatic logic m_ades(input logic st, input logic [2:0] op, input logic [31:0] a, input logic ov);
    logic mis, in_map, terr;
    mis = (op == BE_SW && a[1:0] != 2'b00) || (op == BE_SH && a[0]);
    in_map = (a <= 32'h2FFF) || (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    terr = (a >= 32'h7F08 && a <= 32'h7F0B) || (a >= 32'h7F18 && a <= 32'h7F1B) || (op != BE_SW && a >= 32'h7F00);
    return st && (mis || !in_map || terr || ov);
  endfunction

  function automatic logic m_enq();
    return store && !Req && !m_ades(store, BEOp, Addr, EXC_DMOv) && mq.size() < 4 &&
           (BEOp == BE_SW || BEOp == BE_SH || BEOp == BE_SB);
  endfunction

  task automatic tick();
    logic e, d;
    ent_t x;
    e = m_enq();
    d = mq.size() != 0 && bus_ready;
    x.wa = Addr[31:2];
    x.be = m_be(BEOp, Addr);
    x.d  = m_data(BEOp, Addr, rt_data);
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (d) void'(mq.pop_front());
      if (e) mq.push_back(x);
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; store = 1'b0; BEOp = BE_SW; Addr = 32'h0; rt_data = 32'h0; EXC_DMOv = 1'b0;
    Req = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; ld_valid = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%h exp=1", empty); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_bus_valid got=%h exp=0", bus_valid); end
    checks++; if ({bus_addr, bus_byteen, bus_wdata} !== 68'h0) begin failures++; $display("FAIL reset_bus_fields got=%h/%h/%h exp=0", bus_addr, bus_byteen, bus_wdata); end
    checks++; if ({stall_full, ld_hit} !== 2'b00) begin failures++; $display("FAIL reset_stall_hit got=%b exp=00", {stall_full, ld_hit}); end
  endtask

  task automatic test_sb_format();
    idle();
    bus_ready = 1'b1; store = 1'b1; BEOp = BE_SB; Addr = 32'h13; rt_data = 32'h1234_56AB;
    #1;
    checks++; if (EXC_AdES !== 1'b0) begin failures++; $display("FAIL sb_ades got=%h exp=0", EXC_AdES); end
    tick();
    store = 1'b0;
    #1;
    checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL sb_valid got=%h exp=1", bus_valid); end
    checks++; if (bus_addr !== 32'h10) begin failures++; $display("FAIL sb_addr got=%h exp=10", bus_addr); end
    checks++; if (bus_byteen !== 4'b1000) begin failures++; $display("FAIL sb_byteen got=%b exp=1000", bus_byteen); end
    checks++; if (bus_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", bus_wdata); end
    tick();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sb_empty_after got=%h exp=1", empty); end
  endtask

  task automatic test_ades();
    logic [2:0] ops [6] = '{BE_SH, BE_SW, BE_SB, BE_SW, BE_SW, BE_SB};
    logic [31:0] adr [6] = '{32'h1, 32'h7F08, 32'h7F00, 32'h3000, 32'h7F04, 32'h2FFF};
    logic exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      idle();
      store = 1'b1; BEOp = ops[i]; Addr = adr[i]; rt_data = $urandom;
      #1;
      checks++; if (EXC_AdES !== exp[i]) begin failures++; $display("FAIL ades_%0d got=%h exp=%h", i, EXC_AdES, exp[i]); end
      tick();
      store = 1'b0;
      #1;
      checks++; if (empty !== exp[i]) begin failures++; $display("FAIL ades_enq_%0d empty got=%h exp=%h", i, empty, exp[i]); end
      bus_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] d5;
    idle();
    store = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Addr = 32'(4 * i); rt_data = $urandom;
      tick();
    end
    Addr = 32'h10; d5 = $urandom; rt_data = d5;
    #1;
    checks++; if (stall_full !== 1'b1) begin failures++; $display("FAIL full_stall got=%h exp=1", stall_full); end
    tick();
    #1;
    checks++; if (stall_full !== 1'b1) begin failures++; $display("FAIL full_stall_hold got=%h exp=1", stall_full); end
    bus_ready = 1'b1;
    #1;
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL full_head got=%h exp=0", bus_addr); end
    checks++; if (stall_full !== 1'b1) begin failures++; $display("FAIL full_stall_on_pop got=%h exp=1", stall_full); end
    tick();
    bus_ready = 1'b0;
    #1;
    checks++; if (stall_full !== 1'b0) begin failures++; $display("FAIL full_stall_release got=%h exp=0", stall_full); end
    tick();
    store = 1'b0; bus_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++; if (bus_addr !== 32'(4 * i)) begin failures++; $display("FAIL full_order_%0d got=%h exp=%h", i, bus_addr, 32'(4 * i)); end
      if (i == 4) begin
        checks++; if (bus_wdata !== d5) begin failures++; $display("FAIL full_fifth_data got=%h exp=%h", bus_wdata, d5); end
      end
      tick();
    end
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%h exp=1", empty); end
  endtask

  task automatic test_ld_hit();
    idle();
    store = 1'b1; BEOp = BE_SB; Addr = 32'h13; rt_data = $urandom;
    tick();
    store = 1'b0; ld_valid = 1'b1; ld_addr = 32'h10;
    #1;
    checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL ldhit_match got=%h exp=1", ld_hit); end
    ld_addr = 32'h14;
    #1;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_other got=%h exp=0", ld_hit); end
    store = 1'b1; BEOp = BE_SW; Addr = 32'h40; ld_addr = 32'h42;
    #1;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_same_cycle got=%h exp=0", ld_hit); end
    tick();
    store = 1'b0;
    #1;
    checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL ldhit_next_cycle got=%h exp=1", ld_hit); end
    bus_ready = 1'b1;
    tick(); tick();
    ld_addr = 32'h10;
    #1;
    checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_after_drain got=%h exp=0", ld_hit); end
  endtask

  task automatic test_req();
    idle();
    store = 1'b1; BEOp = BE_SW; Addr = 32'h20; Req = 1'b1;
    tick();
    store = 1'b0; Req = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL req_cancel empty got=%h exp=1", empty); end
    store = 1'b1; Addr = 32'h24; tick();
    Addr = 32'h28; tick();
    store = 1'b0; Req = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus_addr !== 32'h24 + 32'(4 * i)) begin failures++; $display("FAIL req_drain_%0d got=%h exp=%h", i, bus_addr, 32'h24 + 32'(4 * i)); end
      tick();
    end
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL req_drained got=%h exp=1", empty); end
  endtask

  task automatic test_reset_drain();
    idle();
    store = 1'b1; BEOp = BE_SW;
    for (int i = 0; i < 3; i++) begin
      Addr = 32'(16 + 4 * i); rt_data = $urandom;
      tick();
    end
    store = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({empty, bus_valid} !== 2'b10) begin failures++; $display("FAIL rstdrain_flags got=%b exp=10", {empty, bus_valid}); end
    checks++; if ({bus_addr, bus_byteen, bus_wdata} !== 68'h0) begin failures++; $display("FAIL rstdrain_bus got=%h/%h/%h exp=0", bus_addr, bus_byteen, bus_wdata); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic h;
    idle();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom % 100) == 0;
      store = $urandom % 2;
      r = 4'($urandom % 8);
      BEOp = (r < 3) ? BE_SW : (r < 5) ? BE_SH : (r < 7) ? BE_SB : 3'd5;
      r = 4'($urandom % 8);
      Addr = (r < 5) ? 32'($urandom_range(0, 63)) : (r == 5) ? 32'h2FFC + 32'($urandom % 8) :
             (r == 6) ? 32'h7F00 + 32'($urandom % 32) : 32'($urandom);
      rt_data = $urandom;
      EXC_DMOv = ($urandom % 16) == 0;
      Req = ($urandom % 8) == 0;
      bus_ready = ($urandom % 3) == 0;
      ld_valid = $urandom % 2;
      ld_addr = 32'($urandom_range(0, 63));
      #1;
      h = 1'b0;
      foreach (mq[i]) if (mq[i].wa == ld_addr[31:2]) h = 1'b1;
      checks++; if (EXC_AdES !== m_ades(store, BEOp, Addr, EXC_DMOv)) begin failures++; $display("FAIL rnd_ades n=%0d got=%h exp=%h", n, EXC_AdES, m_ades(store, BEOp, Addr, EXC_DMOv)); end
      checks++; if (stall_full !== (store && mq.size() == 4)) begin failures++; $display("FAIL rnd_stall n=%0d got=%h exp=%h", n, stall_full, store && mq.size() == 4); end
      checks++; if ({empty, bus_valid} !== {mq.size() == 0, mq.size() != 0}) begin failures++; $display("FAIL rnd_flags n=%0d got=%b size=%0d", n, {empty, bus_valid}, mq.size()); end
      checks++; if (ld_hit !== (ld_valid && h)) begin failures++; $display("FAIL rnd_ldhit n=%0d got=%h exp=%h", n, ld_hit, ld_valid && h); end
      if (mq.size() != 0) begin
        checks++; if ({bus_addr, bus_byteen, bus_wdata} !== {mq[0].wa, 2'b00, mq[0].be, mq[0].d}) begin failures++; $display("FAIL rnd_head n=%0d got=%h/%h/%h exp=%h/%h/%h", n, bus_addr, bus_byteen, bus_wdata, {mq[0].wa, 2'b00}, mq[0].be, mq[0].d); end
      end else begin
        checks++; if ({bus_addr, bus_byteen, bus_wdata} !== 68'h0) begin failures++; $display("FAIL rnd_idle_bus n=%0d got=%h/%h/%h exp=0", n, bus_addr, bus_byteen, bus_wdata); end
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sb_format();
    test_ades();
    test_full();
    test_ld_hit();
    test_req();
    test_reset_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
